hazard_fwd_ctrl: RTL
====================

Name: hazard_fwd_ctrl

Overview:
- Parametrised hazard and forwarding controller for the 5-stage pipeline; supersedes the two-operand combinational forwarding unit.
- Generates per-source EX operand forwarding selects and the WB→MEM store-data forward.
- Contains a registered load-use stall FSM with configurable load latency, a memory-busy freeze, and a saturating stall-cycle counter.
- Sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers; its stall and bubble outputs drive the PC, IF/ID and ID/EX registers.

Parameters:
- REG_AW, 5: register address width; address 0 is the hard-wired zero register.
- NUM_SRC, 2: source operands per instruction.
- LOAD_LAT, 1: load-use bubbles required; must be ≥1.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_src  in  NUM_SRC*REG_AW  source registers of the instruction in ID; slot k is bits [k*REG_AW +: REG_AW]
- id_src_used  in  NUM_SRC  per-source valid for the ID instruction
- ex_src  in  NUM_SRC*REG_AW  source registers of the instruction in EX
- ex_rd, ex_regwrite, ex_memread  in  REG_AW,1,1  destination and controls of the instruction in EX
- mem_rd, mem_regwrite  in  REG_AW,1  destination and write enable in MEM
- mem_memwrite, mem_rt  in  1,REG_AW  store flag and store-data register in MEM
- wb_rd, wb_regwrite  in  REG_AW,1  destination and write enable in WB
- mem_busy  in  1  data memory not ready this cycle
- stat_clr  in  1  synchronous clear of stall_cnt
- fwd_sel  out  2*NUM_SRC  per source: 00 register file, 01 WB result, 10 MEM result
- fwd_store  out  1  select WB result as store data in MEM
- stall_pc, stall_if_id  out  1,1  hold PC and IF/ID
- bubble_id_ex  out  1  load a NOP into ID/EX
- freeze_all  out  1  hold all pipeline registers
- stall_cnt  out  CNT_W  stall cycles seen
- hz_state  out  2  FSM state for debug

Behaviour:
- Forwarding (combinational, per slot k):
  - Select 10 if mem_regwrite, mem_rd≠0 and mem_rd==ex_src[k].
  - Otherwise select 01 if wb_regwrite, wb_rd≠0 and wb_rd==ex_src[k].
  - Otherwise select 00.
  - MEM always has priority over WB. The zero register is never forwarded.
- fwd_store = mem_memwrite & wb_regwrite & (wb_rd≠0) & (wb_rd==mem_rt). Combinational.
- lu_hit = ex_memread & ex_regwrite & (ex_rd≠0) & OR over k of (id_src_used[k] & id_src[k]==ex_rd).
- FSM states: RUN=0, LU_STALL=1, FREEZE=2. Reset → RUN, with the internal countdown at 0.
- freeze_all = mem_busy, in every state. When mem_busy is high:
  - Next state is FREEZE; the countdown and the return state are held.
  - stall_pc = stall_if_id = 1 and bubble_id_ex = 0.
  - lu_hit is ignored.
- RUN with mem_busy=0:
  - If lu_hit: stall_pc = stall_if_id = bubble_id_ex = 1 in the same cycle (Mealy).
  - If lu_hit and LOAD_LAT>1: go to LU_STALL with countdown = LOAD_LAT-1.
  - If lu_hit and LOAD_LAT=1: stay in RUN.
  - Otherwise all stall outputs are 0.
- LU_STALL with mem_busy=0:
  - stall_pc = stall_if_id = bubble_id_ex = 1.
  - Countdown decrements; go to RUN on the cycle it reaches 0.
  - lu_hit is ignored.
- FREEZE with mem_busy=0:
  - Return to the saved state (RUN or LU_STALL) with the countdown unchanged.
  - Outputs this cycle follow the rules of the returned-to state.
- stall_cnt:
  - Increments (saturating at all ones) each cycle in which stall_if_id or freeze_all is 1.
  - stat_clr has priority: cycles with stat_clr=1 load 0 and do not count.
- Reset asserted mid-stall: all state is cleared immediately and outputs drop the same instant. stall_cnt resets to 0. Combinational outputs follow their inputs.
- hz_state reflects the registered state.

Decomposition:
- Package hazard_pkg holds:
  - fwd-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - the state enum RUN/LU_STALL/FREEZE.
- Sub-module fwd_sel_slot: one source compare producing 2 bits. Instantiated NUM_SRC times in a generate loop.

Test Plan:
- R-type chain: ex_src0=3, mem_rd=3, mem_regwrite=1, wb_rd=3, wb_regwrite=1 → fwd_sel[1:0]=10. With mem_regwrite=0 → 01. With mem_rd=wb_rd=0 → 00.
- Store after load: mem_memwrite=1, mem_rt=7, wb_rd=7, wb_regwrite=1 → fwd_store=1. With wb_rd=0 → fwd_store=0.
- Load-use, LOAD_LAT=1: ex_memread=1, ex_rd=5, id_src0=5 used → one cycle of stall_if_id=bubble_id_ex=1, then 0 once ex_memread drops; stall_cnt=1.
- LOAD_LAT=3: same hit → 3 consecutive stall cycles; hz_state goes RUN→LU_STALL→RUN; stall_cnt=3.
- mem_busy pulsed 2 cycles during the LU_STALL cycle with countdown=1:
  - freeze_all=1 and bubble_id_ex=0 for 2 cycles;
  - then 1 more LU_STALL cycle;
  - stall_cnt=5 total.
- rst_n low during LU_STALL → hz_state=0 and stall outputs 0 immediately. CNT_W=4 with continuous mem_busy → stall_cnt saturates at 15; stat_clr → 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard / forwarding controller.
//   FWD_* : operand-source selects driven onto the EX operand muxes
//   hz_state_e : stall FSM encoding, also exported on the hz_state debug port
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;  // register file value
  localparam logic [1:0] FWD_WB  = 2'b01;  // result currently in WB
  localparam logic [1:0] FWD_MEM = 2'b10;  // result currently in MEM

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FREEZE   = 2'd2
  } hz_state_e;

endpackage

// File: rtl/fwd_sel_slot.sv
// Forwarding select for a single EX source operand.
//   src                   : source register of this operand in EX
//   mem_rd / mem_regwrite : producer in MEM
//   wb_rd  / wb_regwrite  : producer in WB
//   sel                   : FWD_MEM, FWD_WB or FWD_RF
// MEM holds the younger result, so it wins over WB. Register 0 is hard-wired
// zero and is never forwarded even if some instruction "writes" it.
module fwd_sel_slot
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_RF;
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == src)) begin
      sel = FWD_MEM;
    end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline.
//   Inputs : ID/EX/MEM/WB register addresses and write/read controls,
//            mem_busy (data memory not ready), stat_clr (clear stall_cnt)
//   Outputs: fwd_sel (2 bits per EX source), fwd_store (WB->MEM store data),
//            stall_pc / stall_if_id / bubble_id_ex (load-use interlock),
//            freeze_all (memory wait), stall_cnt (saturating statistic),
//            hz_state (registered FSM state, debug)
// Load-use stalls are Mealy in RUN: the first bubble is issued in the same
// cycle the hit is seen, LU_STALL supplies the remaining LOAD_LAT-1 bubbles.
// A memory wait parks the FSM in FREEZE and remembers where to resume.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [NUM_SRC*REG_AW-1:0] ex_src,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic                      ex_regwrite,
  input  logic                      ex_memread,
  input  logic [REG_AW-1:0]         mem_rd,
  input  logic                      mem_regwrite,
  input  logic                      mem_memwrite,
  input  logic [REG_AW-1:0]         mem_rt,
  input  logic [REG_AW-1:0]         wb_rd,
  input  logic                      wb_regwrite,
  input  logic                      mem_busy,
  input  logic                      stat_clr,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      fwd_store,
  output logic                      stall_pc,
  output logic                      stall_if_id,
  output logic                      bubble_id_ex,
  output logic                      freeze_all,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [1:0]                hz_state
);

  // Countdown only needs to hold LOAD_LAT-1.
  localparam int CW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  // ---------------------------------------------------------------------------
  // Operand forwarding
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_slot
    fwd_sel_slot #(.REG_AW(REG_AW)) u_slot (
      .src          (ex_src[k*REG_AW +: REG_AW]),
      .mem_rd       (mem_rd),
      .mem_regwrite (mem_regwrite),
      .wb_rd        (wb_rd),
      .wb_regwrite  (wb_regwrite),
      .sel          (fwd_sel[2*k +: 2])
    );
  end

  assign fwd_store = mem_memwrite & wb_regwrite & (wb_rd != '0) & (wb_rd == mem_rt);

  // ---------------------------------------------------------------------------
  // Load-use detection
  // ---------------------------------------------------------------------------
  logic lu_hit;
  logic src_match;

  always_comb begin
    src_match = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (id_src_used[k] && (id_src[k*REG_AW +: REG_AW] == ex_rd)) begin
        src_match = 1'b1;
      end
    end
    lu_hit = ex_memread & ex_regwrite & (ex_rd != '0) & src_match;
  end

  // ---------------------------------------------------------------------------
  // Stall FSM
  // ---------------------------------------------------------------------------
  hz_state_e      state, state_nxt;
  hz_state_e      ret_state, ret_state_nxt;
  hz_state_e      eff_state;
  logic [CW-1:0]  cnt, cnt_nxt, cnt_dec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      ret_state <= RUN;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_state_nxt;
      cnt       <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    ret_state_nxt = ret_state;
    cnt_nxt       = cnt;
    stall_pc      = 1'b0;
    stall_if_id   = 1'b0;
    bubble_id_ex  = 1'b0;
    cnt_dec       = cnt - CW'(1);
    // Leaving FREEZE behaves exactly like being in the saved state.
    eff_state     = (state == FREEZE) ? ret_state : state;

    if (mem_busy) begin
      // Hold the front end; no bubble, the ID/EX contents must survive.
      stall_pc    = 1'b1;
      stall_if_id = 1'b1;
      state_nxt   = FREEZE;
      if (state != FREEZE) begin
        ret_state_nxt = state;
      end
    end else begin
      unique case (eff_state)
        LU_STALL: begin
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          bubble_id_ex = 1'b1;
          cnt_nxt      = cnt_dec;
          state_nxt    = (cnt_dec == '0) ? RUN : LU_STALL;
        end
        default: begin
          state_nxt = RUN;
          if (lu_hit) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
            if (LOAD_LAT > 1) begin
              state_nxt = LU_STALL;
              cnt_nxt   = CW'(LOAD_LAT - 1);
            end
          end
        end
      endcase
    end
  end

  assign freeze_all = mem_busy;
  assign hz_state   = state;

  // ---------------------------------------------------------------------------
  // Stall-cycle statistic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stat_clr) begin
      stall_cnt <= '0;
    end else if ((stall_if_id || freeze_all) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
